stack_ctrl: RTL
===============

// Module: stack_ctrl
// PURPOSE
//   Push/pop initiator for lifo_bram: executes 4-bit stack-machine instructions (PUSH imm, POP, ALU ops, DUP, SWAP)
//   by sequencing single-cycle WE/RE pulses, honouring LIFO read latency and flag settle time. Sits between the
//   instruction source (UART/host decoder) and the LIFO; keeps its own depth count and reports results/errors.
// PARAMETERS
//   DEPTH      256  stack depth; must equal the LIFO's DEPTH
//   ADDR_W     8    log2(DEPTH)
//   POP_LAT    3    edges from RE-sampled edge to edge where lifo_dout is valid (LIFO+BRAM registers)
//   SETTLE     2    idle cycles after each push (BRAM write + LIFO flag update)
// PORTS
//   clk          in   1         clock
//   nReset       in   1         asynchronous, active-low reset; shared with lifo_bram
//   instr_valid  in   1         instruction offered
//   instr_ready  out  1         high only in IDLE; accept on valid&ready at rising edge
//   instr_op     in   4         opcode
//   instr_imm    in   4         immediate (PUSH only)
//   res_valid    out  1         one-cycle pulse: instruction completed with result
//   res_data     out  4         result (value pushed last, or value popped for POP)
//   res_carry    out  1         ADD carry-out / SUB borrow; 0 otherwise
//   err_valid    out  1         one-cycle pulse: instruction rejected, no LIFO access made
//   err_code     out  2         00 flag desync, 01 underflow, 10 overflow, 11 illegal opcode
//   depth        out  ADDR_W+1  current stack occupancy
//   lifo_we      out  1         push strobe, high exactly one cycle per push
//   lifo_re      out  1         pop strobe, high exactly one cycle per pop; never together with lifo_we
//   lifo_din     out  4         push data, valid while lifo_we high
//   lifo_dout    in   4         pop data from LIFO
//   lifo_full    in   1         LIFO full flag
//   lifo_empty   in   1         LIFO empty flag
// BEHAVIOUR
//   Reset: state IDLE, depth 0, instr_ready 1, every other output 0. Reset mid-instruction aborts it; the LIFO
//     resets together, so both restart empty.
//   Opcodes: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 DUP, 9 SWAP, A-F illegal.
//   Operands: B = top (popped first), A = next. ADD {carry,res}=A+B (5-bit); SUB res=A-B mod 16, carry=(A<B).
//     SWAP pops B,A, pushes B then A. DUP pops A, pushes A twice.
//   Checks at accept, in priority order:
//     opcode>9 -> 11;
//     lifo_empty!=(depth==0) or lifo_full!=(depth==DEPTH) -> 00;
//     pops>depth -> 01;
//     depth-pops+pushes>DEPTH -> 10.
//     Error: ERR state, err_valid pulse, back to IDLE; depth unchanged.
//   FSM (Moore outputs decoded from state reg):
//     IDLE -> ERR | POP (if pops>0) | EXEC.
//     POP: lifo_re=1, depth-1 -> WAITP.
//     WAITP: POP_LAT cycles; on last cycle capture lifo_dout (B, then A) -> POP if pops remain else EXEC.
//     EXEC: ALU compute, load push list (0-2 values) -> PUSH or DONE.
//     PUSH: lifo_we=1, lifo_din=value, depth+1 -> SETTLE.
//     SETTLE: SETTLE cycles -> PUSH if values remain else DONE.
//     DONE: res_valid=1 (0 for NOP), res_data/res_carry held until next DONE -> IDLE.
//   Latency, accept edge to res_valid cycle (defaults):
//     NOP: 2 cycles. PUSH: 5. POP: 6.
//     ADD/SUB/AND/OR/XOR: 13. SWAP: 16. DUP: 12.
//   depth saturates by construction; never wraps. instr_valid outside IDLE is ignored (ready=0).
// STRUCTURE
//   stack_pkg: opcode localparams, err codes, state encoding, per-opcode pop/push count table.
//   Sub-module stack_alu: combinational 4-bit ALU (op, A, B -> res, carry).
//   Everything else (FSM, counters, operand/push regs) in stack_ctrl.
// TESTING (bench instantiates stack_ctrl + lifo_bram + BRAM model)
//   1. Reset; PUSH 5, PUSH 3, ADD -> res_valid res_data=8 carry=0, 13 cycles after ADD accept; depth=1.
//   2. PUSH 9, PUSH C, ADD -> 5 carry=1; PUSH 3, PUSH 5, SUB -> E carry=1.
//   3. depth=1, ADD -> err_valid code 01, no lifo_re pulse, depth stays 1; op F -> code 11.
//   4. DEPTH=4/ADDR_W=2: 4 PUSHes ok, 5th PUSH -> code 10, lifo_we never high; DUP at full -> code 10.
//   5. PUSH 1, PUSH 2, SWAP, POP -> res 1, POP -> res 2, depth=0; lifo_we/lifo_re never coincide.
//   6. nReset low during WAITP of ADD -> outputs reset, ready=1, depth=0; then PUSH 7, POP -> res 7.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack-machine controller.
// Contents: opcode values, error codes, FSM state encoding and the
// per-opcode pop/push count table used by the accept-time checks and
// the push-list loader.
package stack_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_DUP  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;

  localparam logic [1:0] ERR_DESYNC  = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERR    = 3'd1,
    ST_POP    = 3'd2,
    ST_WAITP  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_PUSH   = 3'd5,
    ST_SETTLE = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // Number of LIFO pops an opcode performs (illegal opcodes: none).
  function automatic logic [1:0] op_pops(input logic [3:0] op);
    case (op)
      OP_POP, OP_DUP:                                return 2'd1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP: return 2'd2;
      default:                                       return 2'd0;
    endcase
  endfunction

  // Number of LIFO pushes an opcode performs (illegal opcodes: none).
  function automatic logic [1:0] op_pushes(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 2'd1;
      OP_DUP, OP_SWAP:                               return 2'd2;
      default:                                       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational 4-bit ALU for the stack controller.
// Ports: op (opcode), a (next-of-stack), b (top-of-stack) -> res, carry.
// carry is the ADD carry-out or the SUB borrow (a < b); 0 for other ops.
module stack_alu
  import stack_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] res,
  output logic       carry
);

  // Opcode-selected arithmetic/logic result
  always_comb begin
    res   = 4'd0;
    carry = 1'b0;
    case (op)
      OP_ADD: {carry, res} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        res   = a - b;
        carry = (a < b);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: begin
        res   = 4'd0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop initiator for lifo_bram: executes one stack instruction at a
// time by sequencing single-cycle lifo_re / lifo_we strobes, waiting out
// the LIFO read latency after each pop and the flag settle time after
// each push. Keeps its own occupancy count and cross-checks it against
// the LIFO flags before every instruction.
// Ports: clk/nReset; instruction handshake (instr_valid/ready/op/imm);
// result pulse (res_valid/data/carry); error pulse (err_valid/code);
// depth; LIFO side (lifo_we/re/din out, lifo_dout/full/empty in).
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int POP_LAT = 3,
  parameter int SETTLE  = 2
)(
  input  logic              clk,
  input  logic              nReset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [3:0]        instr_imm,
  output logic              res_valid,
  output logic [3:0]        res_data,
  output logic              res_carry,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   depth,
  output logic              lifo_we,
  output logic              lifo_re,
  output logic [3:0]        lifo_din,
  input  logic [3:0]        lifo_dout,
  input  logic              lifo_full,
  input  logic              lifo_empty
);

  localparam int               CNT_W    = 8;
  localparam int               SUM_W    = ADDR_W + 2;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t            state_r, state_nx;
  logic [3:0]        op_r, imm_r;
  logic [3:0]        last_pop_r, prev_pop_r;   // last_pop = most recent pop
  logic [3:0]        push0_r, push1_r;         // push0 always drives lifo_din
  logic [3:0]        res_data_r;
  logic              res_carry_r;
  logic [1:0]        err_code_r;
  logic [1:0]        pops_left_r, push_left_r;
  logic [ADDR_W:0]   depth_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        pops_s, pushes_s;
  logic [SUM_W-1:0]  after_s;
  logic              chk_err_s;
  logic [1:0]        chk_code_s;
  logic [3:0]        alu_res_s, res_s;
  logic              alu_carry_s, carry_s;

  // After two pops last_pop holds A (second popped) and prev_pop holds B.
  stack_alu u_alu (
    .op    (op_r),
    .a     (last_pop_r),
    .b     (prev_pop_r),
    .res   (alu_res_s),
    .carry (alu_carry_s)
  );

  // Accept-time legality checks, highest priority first
  always_comb begin
    pops_s     = op_pops(instr_op);
    pushes_s   = op_pushes(instr_op);
    after_s    = {1'b0, depth_r} - SUM_W'(pops_s) + SUM_W'(pushes_s);
    chk_err_s  = 1'b1;
    chk_code_s = ERR_ILLEGAL;
    if (instr_op > OP_SWAP) begin
      chk_code_s = ERR_ILLEGAL;
    end else if ((lifo_empty != (depth_r == {(ADDR_W+1){1'b0}})) ||
                 (lifo_full  != (depth_r == DEPTH_V))) begin
      chk_code_s = ERR_DESYNC;
    end else if (SUM_W'(pops_s) > {1'b0, depth_r}) begin
      chk_code_s = ERR_UNDER;
    end else if (after_s > SUM_W'(DEPTH)) begin
      chk_code_s = ERR_OVER;
    end else begin
      chk_err_s  = 1'b0;
      chk_code_s = ERR_DESYNC;
    end
  end

  // Instruction result; operands are stable from EXEC until DONE
  always_comb begin
    res_s   = last_pop_r;
    carry_s = 1'b0;
    case (op_r)
      OP_PUSH: res_s = imm_r;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        res_s   = alu_res_s;
        carry_s = alu_carry_s;
      end
      default: res_s = last_pop_r;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid) begin
          if (chk_err_s)            state_nx = ST_ERR;
          else if (pops_s != 2'd0)  state_nx = ST_POP;
          else                      state_nx = ST_EXEC;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ERR:   state_nx = ST_IDLE;
      ST_POP:   state_nx = ST_WAITP;
      ST_WAITP: begin
        if (cnt_r != CNT_ZERO)          state_nx = ST_WAITP;
        else if (pops_left_r != 2'd0)   state_nx = ST_POP;
        else                            state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_pushes(op_r) != 2'd0)    state_nx = ST_PUSH;
        else                            state_nx = ST_DONE;
      end
      ST_PUSH:  state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt_r != CNT_ZERO)          state_nx = ST_SETTLE;
        else if (push_left_r != 2'd0)   state_nx = ST_PUSH;
        else                            state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_r <= ST_IDLE;
    else         state_r <= state_nx;
  end

  // Datapath: operand capture, push list, counters, depth, result/error regs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      op_r        <= 4'd0;
      imm_r       <= 4'd0;
      last_pop_r  <= 4'd0;
      prev_pop_r  <= 4'd0;
      push0_r     <= 4'd0;
      push1_r     <= 4'd0;
      res_data_r  <= 4'd0;
      res_carry_r <= 1'b0;
      err_code_r  <= 2'b00;
      pops_left_r <= 2'd0;
      push_left_r <= 2'd0;
      depth_r     <= {(ADDR_W+1){1'b0}};
      cnt_r       <= CNT_ZERO;
    end else begin
      // Results change only on entry to DONE; NOP leaves them untouched
      if ((state_nx == ST_DONE) && (state_r != ST_DONE) && (op_r != OP_NOP)) begin
        res_data_r  <= res_s;
        res_carry_r <= carry_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            op_r        <= instr_op;
            imm_r       <= instr_imm;
            pops_left_r <= pops_s;
            if (chk_err_s) err_code_r <= chk_code_s;
          end
        end
        ST_POP: begin
          depth_r     <= depth_r - {{ADDR_W{1'b0}}, 1'b1};
          pops_left_r <= pops_left_r - 2'd1;
          cnt_r       <= CNT_W'(POP_LAT - 1);
        end
        ST_WAITP: begin
          if (cnt_r == CNT_ZERO) begin
            prev_pop_r <= last_pop_r;
            last_pop_r <= lifo_dout;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_EXEC: begin
          push_left_r <= op_pushes(op_r);
          // SWAP pushes B then A; all others push the result (DUP twice)
          push0_r     <= (op_r == OP_SWAP) ? prev_pop_r : res_s;
          push1_r     <= last_pop_r;
        end
        ST_PUSH: begin
          depth_r     <= depth_r + {{ADDR_W{1'b0}}, 1'b1};
          push_left_r <= push_left_r - 2'd1;
          push0_r     <= push1_r;
          cnt_r       <= CNT_W'(SETTLE - 1);
        end
        ST_SETTLE: begin
          if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign instr_ready = (state_r == ST_IDLE);
  assign lifo_re     = (state_r == ST_POP);
  assign lifo_we     = (state_r == ST_PUSH);
  assign lifo_din    = lifo_we ? push0_r : 4'd0;
  assign res_valid   = (state_r == ST_DONE) && (op_r != OP_NOP);
  assign res_data    = res_data_r;
  assign res_carry   = res_carry_r;
  assign err_valid   = (state_r == ST_ERR);
  assign err_code    = err_code_r;
  assign depth       = depth_r;

endmodule
